xillyplayback: RTL and testbench



---
 rtl/xillyplayback_pkg.sv | 17 +
 rtl/xillyplayback_play_fifo.sv | 54 +++++
 rtl/xillyplayback.sv | 144 ++++++++++++++
 tb/tb_xillyplayback.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xillyplayback_pkg.sv
// Shared types and sizing helpers for the host-to-sink playback engine.
package xillyplayback_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREFILL,
        S_PLAY,
        S_DRAIN,
        S_UNDERRUN
    } play_state_t;

    // Occupancy counters need one extra bit so that "full" (== DEPTH) is representable.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/xillyplayback_play_fifo.sv
// Single-clock first-word-fall-through FIFO; dout always shows the head word while !empty.
module play_fifo
    import xillyplayback_pkg::*;
#(
    parameter  int DEPTH = 512,
    localparam int CW    = count_width(DEPTH)
) (
    input  logic          bus_clk,
    input  logic          bus_rst_n,
    input  logic          flush,
    input  logic          wr_en,
    input  logic [31:0]   din,
    input  logic          rd_en,
    output logic [31:0]   dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    localparam int AW = CW - 1;

    logic [31:0]   mem_q [DEPTH];
    logic [CW-1:0] wr_ptr_q;
    logic [CW-1:0] rd_ptr_q;
    logic          do_wr;
    logic          do_rd;

    assign count = wr_ptr_q - rd_ptr_q;
    assign full  = (count == CW'(DEPTH));
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    // Storage carries no reset so it maps onto block/distributed RAM.
    always_ff @(posedge bus_clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + CW'(1);
            if (do_rd) rd_ptr_q <= rd_ptr_q + CW'(1);
        end
    end

endmodule

// File: rtl/xillyplayback.sv
// Playback engine: buffers host words, then releases them to the sink at a paced rate.
// Sink handshake: a word moves when play_valid && play_ready at a rising bus_clk edge.
module xillyplayback
    import xillyplayback_pkg::*;
#(
    parameter int DEPTH    = 512,
    parameter int PREFILL  = 256,
    parameter int PACE_DIV = 32
) (
    input  logic        bus_clk,
    input  logic        bus_rst_n,
    input  logic        user_w_write_32_wren,
    input  logic [31:0] user_w_write_32_data,
    input  logic        user_w_write_32_open,
    output logic        user_w_write_32_full,
    output logic        play_valid,
    output logic [31:0] play_data,
    input  logic        play_ready,
    output logic        play_underrun,
    output logic        play_active,
    output logic [31:0] words_played
);
    localparam int              CW          = count_width(DEPTH);
    localparam int              PW          = (PACE_DIV > 1) ? $clog2(PACE_DIV) : 1;
    localparam logic [PW-1:0]   PACE_RELOAD = PW'(PACE_DIV - 1);
    localparam logic [CW-1:0]   PREFILL_CNT = CW'(PREFILL);

    play_state_t   state_q;
    logic [PW-1:0] pace_q;
    logic          valid_q;
    logic [31:0]   data_q;
    logic          underrun_q;
    logic          active_q;
    logic [31:0]   words_q;

    logic          fifo_full;
    logic          fifo_empty;
    logic [31:0]   fifo_dout;
    logic [CW-1:0] fifo_count;
    logic          tick;
    logic          slot_free;
    logic          running;
    logic          pop;

    assign tick      = (pace_q == '0);
    assign slot_free = !valid_q || play_ready;
    assign running   = (state_q == S_PLAY) || (state_q == S_DRAIN);
    assign pop       = running && tick && slot_free && !fifo_empty;

    // In UNDERRUN the host is never throttled; its words are simply discarded.
    assign user_w_write_32_full = fifo_full && (state_q != S_UNDERRUN);

    play_fifo #(.DEPTH(DEPTH)) u_fifo (
        .bus_clk   (bus_clk),
        .bus_rst_n (bus_rst_n),
        .flush     (state_q == S_IDLE),
        .wr_en     (user_w_write_32_wren && (state_q != S_UNDERRUN)),
        .din       (user_w_write_32_data),
        .rd_en     (pop),
        .dout      (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            state_q    <= S_IDLE;
            underrun_q <= 1'b0;
            active_q   <= 1'b0;
            pace_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (user_w_write_32_open) begin
                        state_q    <= S_PREFILL;
                        underrun_q <= 1'b0;
                    end
                end
                S_PREFILL: begin
                    if (fifo_count >= PREFILL_CNT) begin
                        state_q  <= S_PLAY;
                        active_q <= 1'b1;
                    end else if (!user_w_write_32_open) begin
                        state_q  <= (fifo_count != '0) ? S_DRAIN : S_IDLE;
                        active_q <= (fifo_count != '0);
                    end
                end
                S_PLAY: begin
                    if (!user_w_write_32_open) begin
                        state_q <= S_DRAIN;
                    end else if (tick && slot_free && fifo_empty) begin
                        state_q    <= S_UNDERRUN;
                        underrun_q <= 1'b1;
                        active_q   <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (fifo_empty && !valid_q) begin
                        state_q  <= S_IDLE;
                        active_q <= 1'b0;
                    end
                end
                S_UNDERRUN: begin
                    if (!user_w_write_32_open) state_q <= S_IDLE;
                end
                default: begin
                    state_q  <= S_IDLE;
                    active_q <= 1'b0;
                end
            endcase

            // Counter idles at 0 outside playout, so entry into PLAY pops at once.
            if (pop)                         pace_q <= PACE_RELOAD;
            else if (!running)               pace_q <= '0;
            else if (pace_q != '0)           pace_q <= pace_q - PW'(1);
        end
    end

    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            words_q <= '0;
        end else begin
            if (pop) begin
                data_q  <= fifo_dout;
                valid_q <= 1'b1;
            end else if (slot_free) begin
                valid_q <= 1'b0;
            end

            if ((state_q == S_IDLE) && user_w_write_32_open) words_q <= '0;
            else if (valid_q && play_ready)                    words_q <= words_q + 32'd1;
        end
    end

    assign play_valid    = valid_q;
    assign play_data     = data_q;
    assign play_underrun = underrun_q;
    assign play_active   = active_q;
    assign words_played  = words_q;

endmodule

// File: tb/tb_xillyplayback.sv
// Directed bench: instance A (DEPTH 8, PREFILL 4, PACE_DIV 1) and instance B (DEPTH 16, PREFILL 16, PACE_DIV 4).
module tb_xillyplayback;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  logic        wren_a = 0, open_a = 0, ready_a = 0;
  logic [31:0] wdata_a = '0;
  logic        full_a, valid_a, underrun_a, active_a;
  logic [31:0] data_a, played_a;

  logic        wren_b = 0, open_b = 0, ready_b = 0;
  logic [31:0] wdata_b = '0;
  logic        full_b, valid_b, underrun_b, active_b;
  logic [31:0] data_b, played_b;

  xillyplayback #(.DEPTH(8), .PREFILL(4), .PACE_DIV(1)) dut_a (
    .bus_clk              (clk),
    .bus_rst_n            (rst_n),
    .user_w_write_32_wren (wren_a),
    .user_w_write_32_data (wdata_a),
    .user_w_write_32_open (open_a),
    .user_w_write_32_full (full_a),
    .play_valid           (valid_a),
    .play_data            (data_a),
    .play_ready           (ready_a),
    .play_underrun        (underrun_a),
    .play_active          (active_a),
    .words_played         (played_a)
  );

  xillyplayback #(.DEPTH(16), .PREFILL(16), .PACE_DIV(4)) dut_b (
    .bus_clk              (clk),
    .bus_rst_n            (rst_n),
    .user_w_write_32_wren (wren_b),
    .user_w_write_32_data (wdata_b),
    .user_w_write_32_open (open_b),
    .user_w_write_32_full (full_b),
    .play_valid           (valid_b),
    .play_data            (data_b),
    .play_ready           (ready_b),
    .play_underrun        (underrun_b),
    .play_active          (active_b),
    .words_played         (played_b)
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_b = 32'd500;
  int last_b = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle_a(input string tag);
    int n;
    n = 0;
    repeat (2) step();
    while (n < 300 && (active_a || valid_a)) begin
      step();
      n++;
    end
    check(tag, active_a, 1'b0);
  endtask

  // Scoreboard: every sink transfer on A must match the next expected word.
  always @(negedge clk) begin
    if (rst_n && valid_a && ready_a) begin
      if (exp_q.size() > 0) check("a_xfer_data", data_a, exp_q.pop_front());
      else check("a_sb_underflow", 32'(exp_q.size()), 32'd1);
    end
  end

  always @(negedge clk) begin
    if (rst_n && valid_b && ready_b) begin
      check("b_xfer_data", data_b, exp_b);
      check("b_active", active_b, 1'b1);
      if (last_b >= 0) check("b_spacing", 32'(cyc - last_b), 32'd4);
      last_b = cyc;
      exp_b++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int accepted;
    int n;

    // Reset values
    step();
    step();
    check("rst_valid", valid_a, 1'b0);
    check("rst_data", data_a, 32'd0);
    check("rst_underrun", underrun_a, 1'b0);
    check("rst_active", active_a, 1'b0);
    check("rst_played", played_a, 32'd0);
    check("rst_full", full_a, 1'b0);
    rst_n = 1'b1;
    step();

    // Paced playout on B: 16 words, one transfer every 4 cycles
    ready_b = 1'b1;
    open_b = 1'b1;
    step();
    for (int i = 0; i < 16; i++) begin
      wren_b = 1'b1;
      wdata_b = 32'd500 + 32'(i);
      step();
    end
    wren_b = 1'b0;
    open_b = 1'b0;
    n = 0;
    repeat (2) step();
    while (n < 300 && (active_b || valid_b)) begin
      step();
      n++;
    end
    check("b_idle_timeout", active_b, 1'b0);
    check("b_played", played_b, 32'd16);
    check("b_count", exp_b, 32'd516);
    check("b_underrun", underrun_b, 1'b0);

    // Test 1: prefill of 4, then back-to-back playout
    ready_a = 1'b1;
    open_a = 1'b1;
    step();
    for (int i = 1; i <= 8; i++) begin
      wren_a = 1'b1;
      wdata_a = 32'(i);
      exp_q.push_back(32'(i));
      step();
      if (i == 4) check("t1_valid_after_w4", valid_a, 1'b0);
      if (i == 5) begin
        check("t1_valid_after_w5", valid_a, 1'b0);
        check("t1_active_after_w5", active_a, 1'b1);
      end
      if (i == 6) begin
        check("t1_valid_after_w6", valid_a, 1'b1);
        check("t1_first_data", data_a, 32'd1);
      end
    end
    wren_a = 1'b0;
    open_a = 1'b0;
    repeat (6) step();
    check("t1_played_8", played_a, 32'd8);
    wait_idle_a("t1_idle_timeout");
    check("t1_underrun", underrun_a, 1'b0);
    check("t1_sb_drained", 32'(exp_q.size()), 32'd0);

    // Test 3: starve the FIFO while open
    open_a = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      wren_a = 1'b1;
      wdata_a = 32'd100 + 32'(i);
      exp_q.push_back(32'd100 + 32'(i));
      step();
    end
    wren_a = 1'b0;
    n = 0;
    while (n < 50 && !underrun_a) begin
      step();
      n++;
    end
    check("t3_underrun_set", underrun_a, 1'b1);
    check("t3_played_6", played_a, 32'd6);
    check("t3_active_off", active_a, 1'b0);
    for (int i = 0; i < 3; i++) begin
      wren_a = 1'b1;
      wdata_a = 32'd900 + 32'(i);
      step();
      check("t3_full_forced_0", full_a, 1'b0);
    end
    wren_a = 1'b0;
    repeat (2) step();
    check("t3_played_still_6", played_a, 32'd6);
    check("t3_no_replay", valid_a, 1'b0);
    open_a = 1'b0;
    step();
    check("t3_underrun_sticky", underrun_a, 1'b1);
    open_a = 1'b1;
    step();
    check("t3_reopen_underrun", underrun_a, 1'b0);
    check("t3_reopen_played", played_a, 32'd0);
    repeat (4) step();
    check("t3_dropped_absent", valid_a, 1'b0);
    open_a = 1'b0;
    repeat (2) step();

    // Test 4: short file drains without reaching prefill
    open_a = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      wren_a = 1'b1;
      wdata_a = 32'd200 + 32'(i);
      exp_q.push_back(32'd200 + 32'(i));
      step();
    end
    wren_a = 1'b0;
    open_a = 1'b0;
    wait_idle_a("t4_idle_timeout");
    check("t4_played_3", played_a, 32'd3);
    check("t4_underrun", underrun_a, 1'b0);
    check("t4_sb_drained", 32'(exp_q.size()), 32'd0);

    // Test 5: sink stalled, host fills FIFO to full plus the held word
    ready_a = 1'b0;
    open_a = 1'b1;
    step();
    accepted = 0;
    for (int i = 0; i < 30; i++) begin
      if (!full_a) begin
        wren_a = 1'b1;
        wdata_a = 32'd300 + 32'(accepted);
        exp_q.push_back(32'd300 + 32'(accepted));
        accepted++;
      end else begin
        wren_a = 1'b0;
      end
      step();
    end
    wren_a = 1'b0;
    check("t5_accepted_9", 32'(accepted), 32'd9);
    check("t5_full", full_a, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_hold_valid", valid_a, 1'b1);
      check("t5_hold_data", data_a, 32'd300);
    end
    ready_a = 1'b1;
    open_a = 1'b0;
    wait_idle_a("t5_idle_timeout");
    check("t5_played_9", played_a, 32'd9);
    check("t5_sb_drained", 32'(exp_q.size()), 32'd0);

    // Test 6: asynchronous reset mid-PLAY
    ready_a = 1'b0;
    open_a = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      wren_a = 1'b1;
      wdata_a = 32'd400 + 32'(i);
      step();
    end
    wren_a = 1'b0;
    step();
    check("t6_pre_valid", valid_a, 1'b1);
    check("t6_pre_active", active_a, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", valid_a, 1'b0);
    check("t6_rst_data", data_a, 32'd0);
    check("t6_rst_active", active_a, 1'b0);
    check("t6_rst_played", played_a, 32'd0);
    check("t6_rst_full", full_a, 1'b0);
    exp_q.delete();
    open_a = 1'b0;
    step();
    rst_n = 1'b1;
    ready_a = 1'b1;
    step();
    open_a = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      wren_a = 1'b1;
      wdata_a = 32'd600 + 32'(i);
      exp_q.push_back(32'd600 + 32'(i));
      step();
    end
    wren_a = 1'b0;
    repeat (2) step();
    check("t6_no_early_play", active_a, 1'b0);
    check("t6_no_early_valid", valid_a, 1'b0);
    wren_a = 1'b1;
    wdata_a = 32'd603;
    exp_q.push_back(32'd603);
    step();
    wren_a = 1'b0;
    step();
    check("t6_play_after_prefill", active_a, 1'b1);
    open_a = 1'b0;
    wait_idle_a("t6_idle_timeout");
    check("t6_played_4", played_a, 32'd4);
    check("t6_sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
